// File: rtl/uart_serial_core.sv
// UART serial engine: TX FIFO + shift-out FSM, RX sampler + RX FIFO. Define UART_RX_SYNC_EN for a 2-flop srx_i synchronizer.
// Latency: TX starts on the first baud tick with data queued; an RX entry lands 1 clk after the first stop-bit sample (+2 clk with sync).
// Backpressure: none; TX pushes into a full FIFO are dropped, RX characters arriving at a full FIFO are dropped and raise rf_overrun.

module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_pop   = pop & (count != '0);
    assign do_push  = push & ((count != CNT_W'(DEPTH)) | do_pop);
    assign head_dat = (count == '0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

module uart_serial_core #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             wb_rst_ni,
    input  logic [7:0]       lcr,
    input  logic             enable,
    input  logic             tf_push,
    input  logic [7:0]       tx_data,
    input  logic             tx_reset,
    output logic             stx_o,
    output logic [2:0]       tstate,
    output logic [CNT_W-1:0] tf_count,
    input  logic             srx_i,
    input  logic             rf_pop,
    input  logic             rx_reset,
    input  logic             lsr_mask,
    output logic [10:0]      rf_data_out,
    output logic [CNT_W-1:0] rf_count,
    output logic             rf_error_bit,
    output logic             rf_overrun,
    output logic             rf_push_pulse,
    output logic [9:0]       counter_t,
    output logic [3:0]       rstate
);
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [3:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_PUSH} rx_state_e;

    function automatic logic calc_par(input logic [7:0] d, input logic [1:0] mode);
        // mode[1] = stick, mode[0] = even
        return mode[1] ? ~mode[0] : (mode[0] ? ^d : ~^d);
    endfunction

    logic lcr7_unused;
    assign lcr7_unused = lcr[7];

    // ---------------- transmit ----------------
    tx_state_e  tx_st;
    logic [4:0] tx_tick;
    logic [2:0] tx_bits;
    logic [7:0] tx_shift, tf_head, wmask;
    logic [3:0] tx_lcr;
    logic       tx_line, tx_par, tf_pop;

    assign wmask  = 8'hFF >> (2'd3 - lcr[1:0]);
    assign tf_pop = enable && (tf_count != '0) && (tx_tick == 5'd0) &&
                    (tx_st == TX_IDLE || tx_st == TX_STOP);
    assign stx_o  = tx_line & ~lcr[6];
    assign tstate = tx_st;

    uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk(clk), .rst_n(wb_rst_ni), .push(tf_push), .push_dat(tx_data),
        .pop(tf_pop), .flush(tx_reset), .head_dat(tf_head), .count(tf_count)
    );

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_st    <= TX_IDLE;
            tx_tick  <= 5'd0;
            tx_bits  <= 3'd0;
            tx_shift <= 8'd0;
            tx_lcr   <= 4'd0;
            tx_line  <= 1'b1;
            tx_par   <= 1'b0;
        end else if (enable) begin
            if (tx_tick != 5'd0) begin
                tx_tick <= tx_tick - 5'd1;
            end else begin
                case (tx_st)
                    TX_IDLE, TX_STOP: begin
                        if (tf_count != '0) begin
                            tx_st    <= TX_START;
                            tx_line  <= 1'b0;
                            tx_tick  <= 5'd15;
                            tx_shift <= tf_head & wmask;
                            tx_par   <= calc_par(tf_head & wmask, lcr[5:4]);
                            tx_lcr   <= lcr[3:0];
                        end else begin
                            tx_st   <= TX_IDLE;
                            tx_line <= 1'b1;
                        end
                    end
                    TX_START: begin
                        tx_st    <= TX_DATA;
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bits  <= {1'b1, tx_lcr[1:0]};
                        tx_tick  <= 5'd15;
                    end
                    TX_DATA: begin
                        if (tx_bits != 3'd0) begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bits  <= tx_bits - 3'd1;
                            tx_tick  <= 5'd15;
                        end else if (tx_lcr[3]) begin
                            tx_st   <= TX_PARITY;
                            tx_line <= tx_par;
                            tx_tick <= 5'd15;
                        end else begin
                            tx_st   <= TX_STOP;
                            tx_line <= 1'b1;
                            tx_tick <= tx_lcr[2] ? 5'd31 : 5'd15;
                        end
                    end
                    TX_PARITY: begin
                        tx_st   <= TX_STOP;
                        tx_line <= 1'b1;
                        tx_tick <= tx_lcr[2] ? 5'd31 : 5'd15;
                    end
                    default: begin
                        tx_st   <= TX_IDLE;
                        tx_line <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- receive ----------------
    logic rx_in;
`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rx_sync <= 2'b11;
        else            rx_sync <= {rx_sync[0], srx_i};
    end
    assign rx_in = rx_sync[1];
`else
    assign rx_in = srx_i;
`endif

    rx_state_e  rx_st;
    logic [3:0] rx_tick;
    logic [2:0] rx_idx;
    logic [7:0] rx_data;
    logic [4:0] rx_lcr;     // {stick, even, pe, wlen[1:0]}
    logic       rx_par_bit, rx_perr, rx_ferr, rx_brk;
    logic       rf_push, rf_pop_ok, rf_accept;
    logic [10:0] rf_push_dat;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0] char_bits;
    logic [9:0] reload_t;

    assign rstate      = rx_st;
    assign rf_push     = (rx_st == RX_PUSH);
    assign rf_push_dat = {rx_data, rx_brk, rx_perr, rx_ferr};
    assign rf_pop_ok   = rf_pop & (rf_count != '0);
    assign rf_accept   = rf_push & ((rf_count != CNT_W'(FIFO_DEPTH)) | rf_pop_ok);
    assign rf_error_bit = (err_cnt != '0);

    uart_fifo #(.W(11), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clk(clk), .rst_n(wb_rst_ni), .push(rf_push), .push_dat(rf_push_dat),
        .pop(rf_pop), .flush(rx_reset), .head_dat(rf_data_out), .count(rf_count)
    );

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_st      <= RX_IDLE;
            rx_tick    <= 4'd0;
            rx_idx     <= 3'd0;
            rx_data    <= 8'd0;
            rx_lcr     <= 5'd0;
            rx_par_bit <= 1'b0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_brk     <= 1'b0;
        end else if (rx_reset) begin
            rx_st   <= RX_IDLE;
            rx_tick <= 4'd0;
        end else if (rx_st == RX_PUSH) begin
            rx_st <= RX_IDLE;
        end else if (enable) begin
            if (rx_tick != 4'd0) begin
                rx_tick <= rx_tick - 4'd1;
            end else begin
                case (rx_st)
                    RX_IDLE: if (!rx_in) begin
                        rx_st      <= RX_START;
                        rx_tick    <= 4'd7;
                        rx_idx     <= 3'd0;
                        rx_data    <= 8'd0;
                        rx_par_bit <= 1'b0;
                        rx_perr    <= 1'b0;
                        rx_lcr     <= {lcr[5:3], lcr[1:0]};
                    end
                    RX_START: begin
                        // half a bit later: still low is a real start, high was a glitch
                        if (!rx_in) begin
                            rx_st   <= RX_DATA;
                            rx_tick <= 4'd15;
                        end else begin
                            rx_st <= RX_IDLE;
                        end
                    end
                    RX_DATA: begin
                        rx_data[rx_idx] <= rx_in;
                        rx_idx  <= rx_idx + 3'd1;
                        rx_tick <= 4'd15;
                        if (rx_idx == {1'b1, rx_lcr[1:0]})
                            rx_st <= rx_lcr[2] ? RX_PARITY : RX_STOP;
                    end
                    RX_PARITY: begin
                        rx_par_bit <= rx_in;
                        rx_perr    <= rx_in != calc_par(rx_data, rx_lcr[4:3]);
                        rx_tick    <= 4'd15;
                        rx_st      <= RX_STOP;
                    end
                    RX_STOP: begin
                        rx_ferr <= ~rx_in;
                        rx_brk  <= ~rx_in & (rx_data == 8'd0) & ~rx_par_bit;
                        rx_st   <= RX_PUSH;
                    end
                    default: rx_st <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rf_overrun    <= 1'b0;
            rf_push_pulse <= 1'b0;
            err_cnt       <= '0;
        end else begin
            rf_push_pulse <= rf_accept & ~rx_reset;
            if (rf_push & ~rf_accept)      rf_overrun <= 1'b1;
            else if (lsr_mask | rx_reset)  rf_overrun <= 1'b0;
            if (rx_reset) err_cnt <= '0;
            else          err_cnt <= err_cnt + CNT_W'(rf_accept & (|rf_push_dat[2:0]))
                                             - CNT_W'(rf_pop_ok & (|rf_data_out[2:0]));
        end
    end

    // character time x4 in baud ticks: 1 start + data + parity + stop bits
    assign char_bits = 4'd7 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]} + {3'b000, lcr[2]};
    assign reload_t  = {char_bits, 6'b0} - 10'd1;

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            counter_t <= 10'h3FF;
        else if (rf_count == '0 || rf_push_pulse || rf_pop)
            counter_t <= reload_t;
        else if (enable && counter_t != 10'd0)
            counter_t <= counter_t - 10'd1;
    end
endmodule

// File: tb/tb_uart_serial_core.sv
// Directed bench for uart_serial_core: TX waveform, loopback, RX error flags, break, overrun, timeout counter.
module tb_uart_serial_core;
    logic        clk = 1'b0;
    logic        wb_rst_ni;
    logic [7:0]  lcr;
    logic        enable, tf_push, tx_reset, rf_pop, rx_reset, lsr_mask;
    logic [7:0]  tx_data;
    logic        stx_o, srx_i, rf_error_bit, rf_overrun, rf_push_pulse;
    logic [2:0]  tstate;
    logic [3:0]  rstate;
    logic [4:0]  tf_count, rf_count;
    logic [10:0] rf_data_out;
    logic [9:0]  counter_t;
    logic        loopback, rx_drv;

    assign srx_i = loopback ? stx_o : rx_drv;

    uart_serial_core #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
        .clk(clk), .wb_rst_ni(wb_rst_ni), .lcr(lcr), .enable(enable),
        .tf_push(tf_push), .tx_data(tx_data), .tx_reset(tx_reset),
        .stx_o(stx_o), .tstate(tstate), .tf_count(tf_count),
        .srx_i(srx_i), .rf_pop(rf_pop), .rx_reset(rx_reset), .lsr_mask(lsr_mask),
        .rf_data_out(rf_data_out), .rf_count(rf_count), .rf_error_bit(rf_error_bit),
        .rf_overrun(rf_overrun), .rf_push_pulse(rf_push_pulse),
        .counter_t(counter_t), .rstate(rstate)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_cyc = -1000;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rf_push_pulse === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_bit(input logic b);
        rx_drv = b;
        tick(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int wl, input logic pe,
                              input logic pv, input logic sv);
        rx_bit(1'b0);
        for (int i = 0; i < wl; i++) rx_bit(d[i]);
        if (pe) rx_bit(pv);
        rx_bit(sv);
        rx_bit(1'b1);
    endtask

    task automatic pulse_pop();
        rf_pop = 1'b1;
        tick(1);
        rf_pop = 1'b0;
    endtask

    task automatic pulse_rx_reset();
        rx_reset = 1'b1;
        tick(1);
        rx_reset = 1'b0;
    endtask

    initial begin
        logic [9:0] frame;
        int base;
        wb_rst_ni = 1'b0; lcr = 8'h03; enable = 1'b0; tf_push = 1'b0; tx_data = 8'h00;
        tx_reset = 1'b0; rf_pop = 1'b0; rx_reset = 1'b0; lsr_mask = 1'b0;
        loopback = 1'b0; rx_drv = 1'b1;
        tick(3);
        chk("rst_stx", stx_o, 1);
        chk("rst_tf_count", tf_count, 0);
        chk("rst_rf_count", rf_count, 0);
        chk("rst_tstate", tstate, 0);
        chk("rst_rstate", rstate, 0);
        chk("rst_counter_t", counter_t, 10'h3FF);
        chk("rst_overrun", rf_overrun, 0);
        chk("rst_push_pulse", rf_push_pulse, 0);
        chk("rst_rf_data", rf_data_out, 0);
        wb_rst_ni = 1'b1;
        tick(2);
        chk("ctr_idle_8n1", counter_t, 639);

        // TX FIFO fills to 16, 17th push dropped, flush empties it
        for (int i = 0; i < 17; i++) begin
            tf_push = 1'b1; tx_data = 8'(i);
            tick(1);
        end
        tf_push = 1'b0;
        chk("tf_full_count", tf_count, 16);
        tx_reset = 1'b1; tick(1); tx_reset = 1'b0;
        chk("tf_flush_count", tf_count, 0);
        chk("tf_idle_state", tstate, 0);

        lcr = 8'h43; tick(1);
        chk("break_stx", stx_o, 0);
        chk("break_tstate", tstate, 0);
        lcr = 8'h03; tick(1);

        // 8N1 A5: start, 1,0,1,0,0,1,0,1, stop
        enable = 1'b1;
        tf_push = 1'b1; tx_data = 8'hA5; tick(1); tf_push = 1'b0;
        chk("tx_queued", tf_count, 1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 160; i++) begin
            tick(1);
            if (i == 0) begin
                chk("tx_start_state", tstate, 1);
                chk("tx_popped", tf_count, 0);
            end
            if (i % 16 == 0)  chk($sformatf("tx_bit%0d_first", i / 16), stx_o, frame[i / 16]);
            if (i % 16 == 15) chk($sformatf("tx_bit%0d_last", i / 16), stx_o, frame[i / 16]);
        end
        tick(1);
        chk("tx_back_idle", tstate, 0);
        chk("tx_idle_line", stx_o, 1);

        // 8E1 loopback of 3C
        lcr = 8'h1B; tick(2);
        chk("ctr_idle_8e1", counter_t, 703);
        loopback = 1'b1;
        base = pulses;
        tf_push = 1'b1; tx_data = 8'h3C; tick(1); tf_push = 1'b0;
        tick(16 * 13);
        loopback = 1'b0;
        chk("lb_rf_count", rf_count, 1);
        chk("lb_rf_data", rf_data_out, {8'h3C, 3'b000});
        chk("lb_pulses", pulses - base, 1);
        chk("lb_no_err", rf_error_bit, 0);
        pulse_pop();
        chk("lb_popped", rf_count, 0);

        // parity error then framing error
        send_frame(8'h55, 8, 1'b1, 1'b1, 1'b1);
        send_frame(8'h12, 8, 1'b1, 1'b0, 1'b0);
        tick(16);
        chk("err_rf_count", rf_count, 2);
        chk("err_perr_entry", rf_data_out, {8'h55, 3'b010});
        chk("err_bit_two", rf_error_bit, 1);
        pulse_pop();
        chk("err_ferr_entry", rf_data_out, {8'h12, 3'b001});
        chk("err_bit_one", rf_error_bit, 1);
        pulse_pop();
        chk("err_bit_clear", rf_error_bit, 0);
        chk("err_empty", rf_count, 0);

        // line held low for 12 bit times at 8N1
        lcr = 8'h03; tick(2);
        rx_drv = 1'b0; tick(192);
        rx_drv = 1'b1; tick(16);
        chk("brk_entry", rf_data_out, {8'h00, 3'b101});
        pulse_rx_reset();
        chk("brk_flushed", rf_count, 0);
        chk("brk_rstate", rstate, 0);
        tick(32);

        // 17 characters without popping
        for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
        chk("ovr_count", rf_count, 16);
        chk("ovr_flag", rf_overrun, 1);
        chk("ovr_head", rf_data_out, {8'h40, 3'b000});
        lsr_mask = 1'b1; tick(1); lsr_mask = 1'b0;
        chk("ovr_cleared", rf_overrun, 0);
        pulse_rx_reset();
        chk("ovr_flushed", rf_count, 0);

        // character timeout counter
        send_frame(8'hA7, 8, 1'b0, 1'b0, 1'b1);
        chk("to_rf_count", rf_count, 1);
        chk("to_rf_data", rf_data_out, {8'hA7, 3'b000});
        chk("to_running", counter_t, 639 - (cyc - pulse_cyc - 1));
        while (cyc - pulse_cyc - 1 < 638) tick(1);
        chk("to_one_left", counter_t, 1);
        tick(1);
        chk("to_zero", counter_t, 0);
        tick(60);
        chk("to_hold_zero", counter_t, 0);
        pulse_pop();
        chk("to_reload", counter_t, 639);
        chk("to_empty", rf_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
